// File: rtl/sram_data_memory_controller.sv
// Sequences one 32-bit MEM-stage load/store into two 16-bit accesses on an
// external asynchronous SRAM, freezing the pipeline until the access completes.
module sram_data_memory_controller #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned MEM_BASE    = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LO   = 2'd1;
   localparam logic [1:0] S_HI   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             op_write;
   logic [31:0]      data_q;
   logic [16:0]      word_q;
   logic [16:0]      word_c;
   logic             req_c;
   logic             last_c;
   logic             drive_c;
   logic [15:0]      dq_out_c;

   assign req_c  = mem_read | mem_write;
   assign word_c = 17'((address - 32'(MEM_BASE)) >> 2);

   // Data bus is only driven during the halves of a store.
   assign SRAM_DQ = drive_c ? dq_out_c : 16'bz;

   // State and wait-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next state, wait counter and SRAM strobe decode.
   always_comb begin
      state_next = state;
      cnt_next   = '0;
      ready      = 1'b0;
      SRAM_WE_N  = 1'b1;
      SRAM_OE_N  = 1'b1;
      drive_c    = 1'b0;
      dq_out_c   = data_q[15:0];
      last_c     = (cnt == CNT_LAST);
      case (state)
         S_IDLE: begin
            ready = ~req_c | ~rst_n;
            if (req_c) state_next = S_LO;
         end
         S_LO, S_HI: begin
            if (state == S_HI) dq_out_c = data_q[31:16];
            if (op_write) begin
               drive_c   = 1'b1;
               // WE_N rises on the final wait cycle so data/address hold past the strobe.
               SRAM_WE_N = last_c;
            end else begin
               SRAM_OE_N = 1'b0;
            end
            if (last_c) state_next = (state == S_LO) ? S_HI : S_DONE;
            else        cnt_next   = cnt + CNT_W'(1);
         end
         S_DONE: begin
            ready      = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Request latch, SRAM address and load-result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_write  <= 1'b0;
         data_q    <= '0;
         word_q    <= '0;
         SRAM_ADDR <= '0;
         read_data <= '0;
      end else begin
         if (state == S_IDLE && req_c) begin
            op_write  <= mem_write;
            data_q    <= write_data;
            word_q    <= word_c;
            SRAM_ADDR <= {word_c, 1'b0};
         end
         if (state == S_LO && last_c) begin
            SRAM_ADDR <= {word_q, 1'b1};
            if (!op_write) read_data[15:0] <= SRAM_DQ;
         end
         if (state == S_HI && last_c && !op_write) begin
            read_data[31:16] <= SRAM_DQ;
         end
      end
   end

endmodule

// File: tb/tb_sram_data_memory_controller.sv
// Bench for sram_data_memory_controller: two instances (WAIT_CYCLES 2 and 3),
// a behavioural SRAM on the first, and a per-cycle expectation queue.
module tb_sram_data_memory_controller;

   localparam int unsigned MEM_BASE = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;

   logic        rd2 = 1'b0, wr2 = 1'b0;
   logic [31:0] a2 = '0, d2 = '0, q2;
   logic        rdy2, we2, oe2;
   logic [17:0] sa2;
   wire  [15:0] dq2;

   logic        rd3 = 1'b0, wr3 = 1'b0;
   logic [31:0] a3 = '0, d3 = '0, q3;
   logic        rdy3, we3, oe3;
   logic [17:0] sa3;
   wire  [15:0] dq3;

   logic [15:0] sram [0:255];

   typedef struct {
      logic        ready;
      logic        we_n;
      logic        oe_n;
      logic [17:0] addr;
      logic [15:0] dq;
      logic [31:0] rd;
   } obs_t;

   typedef struct {
      logic        ready;
      logic        we_n;
      logic        oe_n;
      logic        chk_addr;
      logic [17:0] addr;
      logic        chk_dq;
      logic [15:0] dq;
      logic        chk_rd;
      logic [31:0] rd;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] last_rd2 = '0;
   logic [31:0] last_rd3 = '0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   pullup pu_dq2 (dq2);
   pullup pu_dq3 (dq3);

   sram_data_memory_controller #(.WAIT_CYCLES(2), .MEM_BASE(MEM_BASE)) dut2 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd2), .mem_write(wr2),
      .address(a2), .write_data(d2), .read_data(q2), .ready(rdy2),
      .SRAM_ADDR(sa2), .SRAM_DQ(dq2), .SRAM_WE_N(we2), .SRAM_OE_N(oe2)
   );

   sram_data_memory_controller #(.WAIT_CYCLES(3), .MEM_BASE(MEM_BASE)) dut3 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd3), .mem_write(wr3),
      .address(a3), .write_data(d3), .read_data(q3), .ready(rdy3),
      .SRAM_ADDR(sa3), .SRAM_DQ(dq3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3)
   );

   // Asynchronous SRAM model: drives on OE_N low, stores while WE_N low.
   assign dq2 = (!oe2 && we2) ? sram[sa2[7:0]] : 16'bz;

   always @(posedge clk) begin
      if (!we2) sram[sa2[7:0]] <= dq2;
   end

   function automatic obs_t sample(int sel);
      obs_t o;
      if (sel == 3) begin
         o.ready = rdy3; o.we_n = we3; o.oe_n = oe3; o.addr = sa3; o.dq = dq3; o.rd = q3;
      end else begin
         o.ready = rdy2; o.we_n = we2; o.oe_n = oe2; o.addr = sa2; o.dq = dq2; o.rd = q2;
      end
      return o;
   endfunction

   task automatic drive(int sel, logic r, logic w, logic [31:0] a, logic [31:0] d);
      if (sel == 3) begin
         rd3 = r; wr3 = w; a3 = a; d3 = d;
      end else begin
         rd2 = r; wr2 = w; a2 = a; d2 = d;
      end
   endtask

   // One full access: expected per-cycle trace queued up front, then checked cycle by cycle.
   task automatic run_access(int sel, logic r, logic w, logic [31:0] a, logic [31:0] d, string tag);
      int          nw;
      logic [16:0] word;
      logic [31:0] prev, nxt;
      exp_t        e;
      obs_t        o;
      int          k;
      int          i;
      logic        hi;
      nw   = (sel == 3) ? 3 : 2;
      word = 17'((a - 32'(MEM_BASE)) >> 2);
      prev = (sel == 3) ? last_rd3 : last_rd2;
      nxt  = prev;
      if (w) ref_mem[a] = d;
      else   nxt = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
      for (int c = 0; c <= 2*nw+1; c++) begin
         e = '{default: '0};
         e.ready = (c == 2*nw+1);
         e.we_n  = 1'b1;
         e.oe_n  = 1'b1;
         if (c == 0) begin
            e.chk_dq = 1'b1; e.dq = 16'hFFFF;
            e.chk_rd = 1'b1; e.rd = prev;
         end else if (c <= 2*nw) begin
            i  = (c - 1) % nw;
            hi = (c > nw);
            e.chk_addr = 1'b1;
            e.addr     = {word, hi};
            if (w) begin
               e.we_n   = (i == nw - 1);
               e.chk_dq = 1'b1;
               e.dq     = hi ? d[31:16] : d[15:0];
            end else begin
               e.oe_n = 1'b0;
            end
         end else begin
            e.chk_addr = 1'b1; e.addr = {word, 1'b1};
            e.chk_dq   = 1'b1; e.dq   = 16'hFFFF;
            e.chk_rd   = 1'b1; e.rd   = nxt;
         end
         sb.push_back(e);
      end
      k = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         if (k == 0) drive(sel, r, w, a, d);
         #1;
         o = sample(sel);
         e = sb.pop_front();
         n_cmp++;
         if (o.ready !== e.ready) begin
            n_bad++; $display("FAIL %s c%0d ready: got %b want %b", tag, k, o.ready, e.ready);
         end
         n_cmp++;
         if (o.we_n !== e.we_n) begin
            n_bad++; $display("FAIL %s c%0d we_n: got %b want %b", tag, k, o.we_n, e.we_n);
         end
         n_cmp++;
         if (o.oe_n !== e.oe_n) begin
            n_bad++; $display("FAIL %s c%0d oe_n: got %b want %b", tag, k, o.oe_n, e.oe_n);
         end
         if (e.chk_addr) begin
            n_cmp++;
            if (o.addr !== e.addr) begin
               n_bad++; $display("FAIL %s c%0d addr: got %0d want %0d", tag, k, o.addr, e.addr);
            end
         end
         if (e.chk_dq) begin
            n_cmp++;
            if (o.dq !== e.dq) begin
               n_bad++; $display("FAIL %s c%0d dq: got %h want %h", tag, k, o.dq, e.dq);
            end
         end
         if (e.chk_rd) begin
            n_cmp++;
            if (o.rd !== e.rd) begin
               n_bad++; $display("FAIL %s c%0d read_data: got %h want %h", tag, k, o.rd, e.rd);
            end
         end
         k++;
      end
      if (sel == 3) last_rd3 = nxt;
      else          last_rd2 = nxt;
   endtask

   // Drop the request and confirm the controller sits idle and ready.
   task automatic test_idle(int sel, string tag);
      obs_t        o;
      logic [31:0] prev;
      prev = (sel == 3) ? last_rd3 : last_rd2;
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      o = sample(sel);
      n_cmp++;
      if (o.ready !== 1'b1) begin n_bad++; $display("FAIL %s ready: got %b want 1", tag, o.ready); end
      n_cmp++;
      if (o.we_n !== 1'b1 || o.oe_n !== 1'b1) begin
         n_bad++; $display("FAIL %s strobes: got we_n=%b oe_n=%b want 1/1", tag, o.we_n, o.oe_n);
      end
      n_cmp++;
      if (o.dq !== 16'hFFFF) begin n_bad++; $display("FAIL %s dq: got %h want released", tag, o.dq); end
      n_cmp++;
      if (o.rd !== prev) begin n_bad++; $display("FAIL %s read_data: got %h want %h", tag, o.rd, prev); end
   endtask

   task automatic test_reset();
      obs_t o;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int s = 2; s <= 3; s++) begin
         o = sample(s);
         n_cmp++;
         if (o.ready !== 1'b1 || o.we_n !== 1'b1 || o.oe_n !== 1'b1) begin
            n_bad++;
            $display("FAIL reset%0d ctl: got ready=%b we_n=%b oe_n=%b want 1/1/1", s, o.ready, o.we_n, o.oe_n);
         end
         n_cmp++;
         if (o.dq !== 16'hFFFF) begin n_bad++; $display("FAIL reset%0d dq: got %h want released", s, o.dq); end
         n_cmp++;
         if (o.rd !== 32'h0) begin n_bad++; $display("FAIL reset%0d read_data: got %h want 0", s, o.rd); end
         n_cmp++;
         if (o.addr !== 18'h0) begin n_bad++; $display("FAIL reset%0d addr: got %0d want 0", s, o.addr); end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_store();
      run_access(2, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, "store");
      test_idle(2, "store_idle");
   endtask

   task automatic test_load();
      run_access(2, 1'b1, 1'b0, 32'd1028, 32'h0, "load");
      test_idle(2, "load_idle");
   endtask

   task automatic test_back_to_back();
      run_access(2, 1'b0, 1'b1, 32'd1032, 32'h13572468, "b2b_fill");
      test_idle(2, "b2b_fill_idle");
      run_access(2, 1'b1, 1'b0, 32'd1028, 32'h0, "b2b_ld0");
      run_access(2, 1'b1, 1'b0, 32'd1032, 32'h0, "b2b_ld1");
      test_idle(2, "b2b_idle");
   endtask

   task automatic test_reset_in_hi();
      obs_t o;
      @(negedge clk);
      drive(2, 1'b0, 1'b1, 32'd1036, 32'hA5A55A5A);
      repeat (3) @(negedge clk);
      #1;
      o = sample(2);
      n_cmp++;
      if (o.we_n !== 1'b0 || o.dq !== 16'hA5A5) begin
         n_bad++; $display("FAIL rst_hi pre: got we_n=%b dq=%h want 0/a5a5", o.we_n, o.dq);
      end
      rst_n = 1'b0;
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      o = sample(2);
      n_cmp++;
      if (o.we_n !== 1'b1 || o.oe_n !== 1'b1) begin
         n_bad++; $display("FAIL rst_hi strobes: got we_n=%b oe_n=%b want 1/1", o.we_n, o.oe_n);
      end
      n_cmp++;
      if (o.dq !== 16'hFFFF) begin n_bad++; $display("FAIL rst_hi dq: got %h want released", o.dq); end
      n_cmp++;
      if (o.ready !== 1'b1) begin n_bad++; $display("FAIL rst_hi ready: got %b want 1", o.ready); end
      n_cmp++;
      if (o.rd !== 32'h0) begin n_bad++; $display("FAIL rst_hi read_data: got %h want 0", o.rd); end
      last_rd2 = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      run_access(2, 1'b0, 1'b1, 32'd1036, 32'h0BADF00D, "rst_hi_store");
      test_idle(2, "rst_hi_idle");
      run_access(2, 1'b1, 1'b0, 32'd1036, 32'h0, "rst_hi_load");
      test_idle(2, "rst_hi_idle2");
   endtask

   task automatic test_both_high();
      run_access(3, 1'b1, 1'b1, 32'd1024, 32'h600DCAFE, "both_w3");
      test_idle(3, "both_idle");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) sram[i] = 16'h0;
      test_reset();
      test_store();
      test_load();
      test_back_to_back();
      test_reset_in_hi();
      test_both_high();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
